// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit
// Description : RV32I main control with ID/EX, EX/MEM, MEM/WB control staging,
//               load-use stall/bubble and taken-branch flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int ALUOP_W     = 2,
    parameter int EXT_OPCODES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken_ex,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  ex_ALUSrc,
    output logic                  ex_ASrcPC,
    output logic                  ex_Branch,
    output logic                  ex_Jump,
    output logic [ALUOP_W-1:0]    ex_ALUOp,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_RegWrite,
    output logic                  wb_MemToReg,
    output logic                  wb_Link,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  illegal_instr
);

    localparam logic [6:0] C_OP_R      = 7'b0110011;
    localparam logic [6:0] C_OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;

    localparam logic C_EXT_EN = (EXT_OPCODES != 0);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic                  a_src_pc;
        logic                  mem_to_reg;
        logic                  link;
        logic                  illegal;
        logic [ALUOP_W-1:0]    alu_op;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  link;
        logic                  illegal;
        logic [REG_ADDR_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  link;
        logic                  illegal;
        logic [REG_ADDR_W-1:0] rd;
    } memwb_t;

    idex_t  w_dec;
    logic   w_uses_rs1;
    logic   w_uses_rs2;
    logic   w_hazard;
    logic   w_bubble;

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    // ------------------------------------------------------------------------
    // ID decode: control word plus source-register usage flags
    // ------------------------------------------------------------------------
    always_comb begin
        w_dec      = '0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_dec.rd   = id_rd;
        unique case (opcode)
            C_OP_R: begin
                w_dec.reg_write   = 1'b1;
                w_dec.alu_op[1:0] = 2'b10;
                w_uses_rs1        = 1'b1;
                w_uses_rs2        = 1'b1;
            end
            C_OP_I_ALU: begin
                w_dec.reg_write   = 1'b1;
                w_dec.alu_src     = 1'b1;
                w_dec.alu_op[1:0] = 2'b10;
                w_uses_rs1        = 1'b1;
            end
            C_OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_uses_rs1       = 1'b1;
            end
            C_OP_STORE: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_uses_rs1      = 1'b1;
                w_uses_rs2      = 1'b1;
            end
            C_OP_BRANCH: begin
                w_dec.branch      = 1'b1;
                w_dec.alu_op[1:0] = 2'b01;
                w_uses_rs1        = 1'b1;
                w_uses_rs2        = 1'b1;
            end
            C_OP_JAL: begin
                if (C_EXT_EN) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.jump      = 1'b1;
                    w_dec.a_src_pc  = 1'b1;
                    w_dec.link      = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            C_OP_JALR: begin
                if (C_EXT_EN) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.jump      = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.link      = 1'b1;
                    w_uses_rs1      = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            C_OP_LUI: begin
                if (C_EXT_EN) begin
                    w_dec.reg_write   = 1'b1;
                    w_dec.alu_src     = 1'b1;
                    w_dec.alu_op[1:0] = 2'b11;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            C_OP_AUIPC: begin
                if (C_EXT_EN) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.a_src_pc  = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Hazard / flush control
    // ------------------------------------------------------------------------
    always_comb begin
        w_hazard = idex_q.mem_read && (idex_q.rd != '0) &&
                   ((w_uses_rs1 && (id_rs1 == idex_q.rd)) ||
                    (w_uses_rs2 && (id_rs2 == idex_q.rd)));
        w_bubble = branch_taken_ex || w_hazard;
        // A flush overrides the stall: the stalled ID instruction is discarded anyway.
        pc_write    = branch_taken_ex || !w_hazard;
        if_id_write = branch_taken_ex || !w_hazard;
        if_id_flush = branch_taken_ex;
    end

    // ------------------------------------------------------------------------
    // Stage next-state
    // ------------------------------------------------------------------------
    always_comb begin
        idex_d = w_bubble ? idex_t'('0) : w_dec;

        exmem_d            = '0;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.link       = idex_q.link;
        exmem_d.illegal    = idex_q.illegal;
        exmem_d.rd         = idex_q.rd;

        memwb_d            = '0;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.link       = exmem_q.link;
        memwb_d.illegal    = exmem_q.illegal;
        memwb_d.rd         = exmem_q.rd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // ------------------------------------------------------------------------
    // Staged outputs
    // ------------------------------------------------------------------------
    assign ex_ALUSrc     = idex_q.alu_src;
    assign ex_ASrcPC     = idex_q.a_src_pc;
    assign ex_Branch     = idex_q.branch;
    assign ex_Jump       = idex_q.jump;
    assign ex_ALUOp      = idex_q.alu_op;
    assign ex_rd         = idex_q.rd;
    assign mem_MemRead   = exmem_q.mem_read;
    assign mem_MemWrite  = exmem_q.mem_write;
    assign mem_rd        = exmem_q.rd;
    assign wb_RegWrite   = memwb_q.reg_write;
    assign wb_MemToReg   = memwb_q.mem_to_reg;
    assign wb_Link       = memwb_q.link;
    assign wb_rd         = memwb_q.rd;
    assign illegal_instr = memwb_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_control_unit
// Description : Directed self-checking bench; one instance with extended
//               opcodes enabled and one with them disabled share the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_taken_ex;

    logic       pc_write, if_id_write, if_id_flush;
    logic       ex_ALUSrc, ex_ASrcPC, ex_Branch, ex_Jump;
    logic [1:0] ex_ALUOp;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_MemRead, mem_MemWrite;
    logic       wb_RegWrite, wb_MemToReg, wb_Link, illegal_instr;

    logic       pc_write_0, if_id_write_0, if_id_flush_0;
    logic       ex_ALUSrc_0, ex_ASrcPC_0, ex_Branch_0, ex_Jump_0;
    logic [1:0] ex_ALUOp_0;
    logic [4:0] ex_rd_0, mem_rd_0, wb_rd_0;
    logic       mem_MemRead_0, mem_MemWrite_0;
    logic       wb_RegWrite_0, wb_MemToReg_0, wb_Link_0, illegal_instr_0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .EXT_OPCODES(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .ex_ALUSrc(ex_ALUSrc), .ex_ASrcPC(ex_ASrcPC), .ex_Branch(ex_Branch),
        .ex_Jump(ex_Jump), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_rd(mem_rd),
        .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_Link(wb_Link),
        .wb_rd(wb_rd), .illegal_instr(illegal_instr)
    );

    pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .EXT_OPCODES(0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write_0), .if_id_write(if_id_write_0), .if_id_flush(if_id_flush_0),
        .ex_ALUSrc(ex_ALUSrc_0), .ex_ASrcPC(ex_ASrcPC_0), .ex_Branch(ex_Branch_0),
        .ex_Jump(ex_Jump_0), .ex_ALUOp(ex_ALUOp_0), .ex_rd(ex_rd_0),
        .mem_MemRead(mem_MemRead_0), .mem_MemWrite(mem_MemWrite_0), .mem_rd(mem_rd_0),
        .wb_RegWrite(wb_RegWrite_0), .wb_MemToReg(wb_MemToReg_0), .wb_Link(wb_Link_0),
        .wb_rd(wb_rd_0), .illegal_instr(illegal_instr_0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
        opcode = op;
        id_rs1 = rs1;
        id_rs2 = rs2;
        id_rd  = rd;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        branch_taken_ex = 1'b0;
        put(OP_I, 5'd0, 5'd0, 5'd0);
        tick();
        tick();

        // reset state
        chk("rst_ex_alusrc",  {31'd0, ex_ALUSrc},   32'd0);
        chk("rst_ex_aluop",   {30'd0, ex_ALUOp},    32'd0);
        chk("rst_mem_memrd",  {31'd0, mem_MemRead}, 32'd0);
        chk("rst_wb_regwr",   {31'd0, wb_RegWrite}, 32'd0);
        chk("rst_illegal",    {31'd0, illegal_instr}, 32'd0);
        chk("rst_pc_write",   {31'd0, pc_write},    32'd1);
        chk("rst_ifid_write", {31'd0, if_id_write}, 32'd1);
        chk("rst_ifid_flush", {31'd0, if_id_flush}, 32'd0);

        // R, load, store, branch sequence
        reset = 1'b1;
        put(OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        chk("seq_ex_aluop_r", {30'd0, ex_ALUOp}, 32'd2);
        chk("seq_ex_rd_r",    {27'd0, ex_rd},    32'd3);
        put(OP_LOAD, 5'd1, 5'd0, 5'd6);
        tick();
        chk("seq_ex_aluop_ld",  {30'd0, ex_ALUOp},  32'd0);
        chk("seq_ex_alusrc_ld", {31'd0, ex_ALUSrc}, 32'd1);
        put(OP_STORE, 5'd1, 5'd2, 5'd0);
        tick();
        chk("seq_ex_aluop_st", {30'd0, ex_ALUOp},    32'd0);
        chk("seq_mem_memrd",   {31'd0, mem_MemRead}, 32'd1);
        chk("seq_wb_regwr_r",  {31'd0, wb_RegWrite}, 32'd1);
        chk("seq_wb_m2r_r",    {31'd0, wb_MemToReg}, 32'd0);
        chk("seq_wb_rd_r",     {27'd0, wb_rd},       32'd3);
        put(OP_BRANCH, 5'd1, 5'd2, 5'd0);
        tick();
        chk("seq_ex_aluop_br",  {30'd0, ex_ALUOp},     32'd1);
        chk("seq_ex_branch",    {31'd0, ex_Branch},    32'd1);
        chk("seq_mem_memwr",    {31'd0, mem_MemWrite}, 32'd1);
        chk("seq_wb_regwr_ld",  {31'd0, wb_RegWrite},  32'd1);
        chk("seq_wb_m2r_ld",    {31'd0, wb_MemToReg},  32'd1);
        put(OP_I, 5'd0, 5'd0, 5'd0);
        tick();
        chk("seq_wb_regwr_st", {31'd0, wb_RegWrite}, 32'd0);
        tick();
        chk("seq_wb_regwr_br", {31'd0, wb_RegWrite}, 32'd0);
        chk("seq_wb_m2r_br",   {31'd0, wb_MemToReg}, 32'd0);

        // load-use stall
        put(OP_LOAD, 5'd1, 5'd0, 5'd5);
        tick();
        put(OP_R, 5'd1, 5'd5, 5'd7);
        chk("lu_pc_write",   {31'd0, pc_write},    32'd0);
        chk("lu_ifid_write", {31'd0, if_id_write}, 32'd0);
        chk("lu_ifid_flush", {31'd0, if_id_flush}, 32'd0);
        tick();
        chk("lu_bub_aluop",  {30'd0, ex_ALUOp},  32'd0);
        chk("lu_bub_rd",     {27'd0, ex_rd},     32'd0);
        chk("lu_bub_alusrc", {31'd0, ex_ALUSrc}, 32'd0);
        chk("lu_mem_load",   {31'd0, mem_MemRead}, 32'd1);
        chk("lu_pc_resume",  {31'd0, pc_write},  32'd1);
        tick();
        chk("lu_r_aluop", {30'd0, ex_ALUOp}, 32'd2);
        chk("lu_r_rd",    {27'd0, ex_rd},    32'd7);
        chk("lu_mem_bub", {31'd0, mem_MemRead}, 32'd0);

        // no stall: load to x0, then LUI after load rd=5
        put(OP_LOAD, 5'd1, 5'd0, 5'd0);
        tick();
        put(OP_R, 5'd0, 5'd0, 5'd8);
        chk("x0_no_stall", {31'd0, pc_write}, 32'd1);
        put(OP_LOAD, 5'd1, 5'd0, 5'd5);
        tick();
        put(OP_LUI, 5'd5, 5'd5, 5'd9);
        chk("lui_no_stall", {31'd0, if_id_write}, 32'd1);
        tick();
        chk("lui_aluop", {30'd0, ex_ALUOp}, 32'd3);

        // flush beats a simultaneous load-use hazard
        put(OP_LOAD, 5'd1, 5'd0, 5'd5);
        tick();
        branch_taken_ex = 1'b1;
        put(OP_R, 5'd5, 5'd2, 5'd10);
        chk("fl_ifid_flush", {31'd0, if_id_flush}, 32'd1);
        chk("fl_pc_write",   {31'd0, pc_write},    32'd1);
        chk("fl_ifid_write", {31'd0, if_id_write}, 32'd1);
        tick();
        branch_taken_ex = 1'b0;
        put(OP_I, 5'd0, 5'd0, 5'd0);
        chk("fl_bub_aluop", {30'd0, ex_ALUOp},    32'd0);
        chk("fl_bub_rd",    {27'd0, ex_rd},       32'd0);
        chk("fl_mem_load",  {31'd0, mem_MemRead}, 32'd1);
        chk("fl_mem_rd",    {27'd0, mem_rd},      32'd5);

        // JAL with and without extended opcodes
        put(OP_JAL, 5'd0, 5'd0, 5'd1);
        tick();
        chk("jal_ex_jump",   {31'd0, ex_Jump},     32'd1);
        chk("jal_ex_asrcpc", {31'd0, ex_ASrcPC},   32'd1);
        chk("jal0_ex_jump",  {31'd0, ex_Jump_0},   32'd0);
        chk("jal0_ex_asrc",  {31'd0, ex_ASrcPC_0}, 32'd0);
        chk("jal0_illegal_early", {31'd0, illegal_instr_0}, 32'd0);
        put(OP_I, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk("jal_wb_link",     {31'd0, wb_Link},         32'd1);
        chk("jal_wb_regwr",    {31'd0, wb_RegWrite},     32'd1);
        chk("jal_illegal",     {31'd0, illegal_instr},   32'd0);
        chk("jal0_illegal",    {31'd0, illegal_instr_0}, 32'd1);
        chk("jal0_wb_regwr",   {31'd0, wb_RegWrite_0},   32'd0);
        chk("jal0_wb_link",    {31'd0, wb_Link_0},       32'd0);

        // unknown opcode
        put(OP_BAD, 5'd0, 5'd0, 5'd0);
        tick();
        chk("bad_ex_aluop", {30'd0, ex_ALUOp}, 32'd0);
        put(OP_I, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk("bad_illegal",  {31'd0, illegal_instr}, 32'd1);
        chk("bad_wb_regwr", {31'd0, wb_RegWrite},   32'd0);

        // mid-stream reset
        put(OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        put(OP_LOAD, 5'd1, 5'd0, 5'd4);
        tick();
        put(OP_R, 5'd1, 5'd2, 5'd6);
        tick();
        chk("pre_rst_wb_regwr", {31'd0, wb_RegWrite}, 32'd1);
        reset = 1'b0;
        tick();
        chk("mrst_ex_aluop",  {30'd0, ex_ALUOp},     32'd0);
        chk("mrst_ex_rd",     {27'd0, ex_rd},        32'd0);
        chk("mrst_mem_memrd", {31'd0, mem_MemRead},  32'd0);
        chk("mrst_wb_regwr",  {31'd0, wb_RegWrite},  32'd0);
        chk("mrst_wb_rd",     {27'd0, wb_rd},        32'd0);
        chk("mrst_illegal",   {31'd0, illegal_instr}, 32'd0);
        chk("mrst_pc_write",  {31'd0, pc_write},     32'd1);
        reset = 1'b1;
        put(OP_I, 5'd0, 5'd0, 5'd0);
        tick();
        chk("post_rst_wb_regwr", {31'd0, wb_RegWrite}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
